// File: rtl/ehl_apb_mem_fill_if.sv
// ehl_apb_mem_fill_if: APB bus between the fill/check master and the SPRAM slave
interface ehl_apb_mem_fill_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    modport master (output paddr, psel, penable, pwrite, pwdata, input pready, pslverr, prdata);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output pready, pslverr, prdata);
endinterface

// File: rtl/ehl_apb_mem_fill.sv
// ehl_apb_mem_fill: APB master that fills an SPRAM window with a pattern and/or reads it back and counts errors
module ehl_apb_mem_fill #(
    parameter int AWIDTH = 10,
    parameter int CNT_W  = 16
) (
    input  logic               i_pclk,
    input  logic               i_preset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_pattern,
    input  logic [AWIDTH-1:0]  i_base_adr,
    input  logic [CNT_W-1:0]   i_num_words,
    input  logic [31:0]        i_seed,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_aborted,
    output logic [CNT_W-1:0]   o_err_cnt,
    output logic [AWIDTH-1:0]  o_first_err_adr,
    ehl_apb_mem_fill_if.master apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              r_state;
    logic [1:0]          r_pattern;
    logic [AWIDTH-1:0]   r_base;
    logic [CNT_W-1:0]    r_num;
    logic [31:0]         r_seed;
    logic                r_two;
    logic                r_wr;
    logic [CNT_W-1:0]    r_idx;
    logic [AWIDTH-1:0]   r_adr;
    logic                r_psel;
    logic                r_penable;
    logic [31:0]         r_pwdata;
    logic                r_busy;
    logic                r_done;
    logic                r_aborted;
    logic [CNT_W-1:0]    r_err;
    logic [AWIDTH-1:0]   r_first;

    logic                w_err;
    logic                w_last;
    logic                w_sw;
    logic [31:0]         w_exp;
    logic [CNT_W-1:0]    w_nidx;
    logic [AWIDTH-1:0]   w_nadr;
    logic [31:0]         w_nwdata;
    logic [AWIDTH-1:0]   w_base;
    logic                w_swr;
    logic [31:0]         w_swdata;

    // Word value for a given index/address: used both as write data and as read expectation
    function automatic logic [31:0] f_pat(input logic [1:0] p, input logic [31:0] s,
                                          input logic [CNT_W-1:0] idx, input logic [AWIDTH-1:0] adr);
        logic [31:0] a;
        a = 32'(adr);
        return p == 2'd0 ? s : p == 2'd1 ? s + 32'(idx) : p == 2'd2 ? a : ~a;
    endfunction

    // Completion decode and precomputed values for the next word or for a fresh start
    always_comb begin
        w_exp    = f_pat(r_pattern, r_seed, r_idx, r_adr);
        w_err    = r_state == ACCESS && apb.pready && (apb.pslverr || (!r_wr && apb.prdata != w_exp));
        w_last   = r_idx + CNT_W'(1) == r_num;
        w_sw     = w_last && r_wr && r_two;
        w_nidx   = w_sw ? '0 : r_idx + CNT_W'(1);
        w_nadr   = w_sw ? r_base : r_adr + AWIDTH'(4);
        w_nwdata = r_wr && !w_sw ? f_pat(r_pattern, r_seed, w_nidx, w_nadr) : 32'd0;
        w_base   = i_base_adr & ~AWIDTH'(3);
        w_swr    = i_mode == 2'd0 || i_mode == 2'd2;
        w_swdata = w_swr ? f_pat(i_pattern, i_seed, '0, w_base) : 32'd0;
    end

    // Run FSM; every APB and status output is a flop so nothing glitches toward the slave
    always_ff @(posedge i_pclk or posedge i_preset) begin
        if (i_preset) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_base    <= '0;
            r_num     <= '0;
            r_seed    <= '0;
            r_two     <= 1'b0;
            r_wr      <= 1'b0;
            r_idx     <= '0;
            r_adr     <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwdata  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= '0;
            r_first   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pattern <= i_pattern;
                        r_base    <= w_base;
                        r_num     <= i_num_words;
                        r_seed    <= i_seed;
                        r_two     <= i_mode == 2'd2;
                        r_err     <= '0;
                        r_first   <= '0;
                        r_aborted <= 1'b0;
                        r_idx     <= '0;
                        if (i_num_words != '0) begin
                            r_wr     <= w_swr;
                            r_adr    <= w_base;
                            r_pwdata <= w_swdata;
                            r_psel   <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= SETUP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        if (w_err) begin
                            r_err <= r_err + CNT_W'(r_err != '1);
                            if (r_err == '0)
                                r_first <= r_adr;
                        end
                        r_penable <= 1'b0;
                        if (i_abort || (w_last && !w_sw)) begin
                            r_psel    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= i_abort;
                            r_state   <= DONE;
                        end else begin
                            r_idx    <= w_nidx;
                            r_adr    <= w_nadr;
                            r_pwdata <= w_nwdata;
                            r_wr     <= r_wr && !w_sw;
                            r_state  <= SETUP;
                        end
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign apb.paddr       = {{(32-AWIDTH){1'b0}}, r_adr};
    assign apb.psel        = r_psel;
    assign apb.penable     = r_penable;
    assign apb.pwrite      = r_wr;
    assign apb.pwdata      = r_pwdata;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_aborted       = r_aborted;
    assign o_err_cnt       = r_err;
    assign o_first_err_adr = r_first;
endmodule

// File: tb/tb_ehl_apb_mem_fill.sv
// tb_ehl_apb_mem_fill: directed and random runs against an SPRAM slave model and a word-list reference
module tb_ehl_apb_mem_fill;
    typedef struct {
        logic [31:0] adr;
        logic        wr;
        logic [31:0] data;
        logic [31:0] rdata;
        logic        slverr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort;
    logic [1:0]  mode = '0;
    logic [1:0]  pattern = '0;
    logic [9:0]  base = '0;
    logic [15:0] num = '0;
    logic [31:0] seed = '0;
    logic        busy, done, aborted;
    logic [15:0] err_cnt;
    logic [9:0]  first_err;

    rec_t        got[$];
    rec_t        exp_q[$];
    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          stall_max = 0;
    int          abort_at = -1;
    int          slverr_at = -1;
    int          stall_left = 0;
    logic        p_stall = 1'b0;
    logic [31:0] p_adr, p_wd;
    logic        p_wr;

    always #5 clk = ~clk;

    ehl_apb_mem_fill_if bus ();

    ehl_apb_mem_fill #(.AWIDTH(10), .CNT_W(16)) dut (
        .i_pclk(clk), .i_preset(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
        .i_pattern(pattern), .i_base_adr(base), .i_num_words(num), .i_seed(seed),
        .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_err_cnt(err_cnt),
        .o_first_err_adr(first_err), .apb(bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] pat(input logic [1:0] p, input logic [31:0] s, input int i, input logic [9:0] a);
        case (p)
            2'd0:    return s;
            2'd1:    return s + 32'(i);
            2'd2:    return {22'd0, a};
            default: return ~{22'd0, a};
        endcase
    endfunction

    // SPRAM slave with random wait states, error injection, abort driver and protocol checks
    always @(negedge clk) begin
        rec_t r;
        if (!rst) begin
            if (bus.penable) chk("penable_without_psel", bus.psel, 1);
            if (p_stall) begin
                chk("stall_hold_en", bus.penable, 1);
                chk("stall_hold_addr", bus.paddr, p_adr);
                chk("stall_hold_wr", bus.pwrite, p_wr);
                chk("stall_hold_wdata", bus.pwdata, p_wd);
            end
            if (bus.psel && !bus.pwrite) chk("read_wdata_zero", bus.pwdata, 0);
        end
        abort = bus.psel && got.size() == abort_at;
        bus.pready = 1'b1;
        bus.pslverr = 1'b0;
        bus.prdata = '0;
        if (rst) stall_left = 0;
        else if (bus.psel && !bus.penable) stall_left = stall_max > 0 ? int'($urandom_range(stall_max, 0)) : 0;
        else if (bus.psel && bus.penable) begin
            if (stall_left > 0) begin
                bus.pready = 1'b0;
                stall_left--;
            end else begin
                r.adr = bus.paddr;
                r.wr = bus.pwrite;
                r.data = bus.pwdata;
                r.slverr = got.size() == slverr_at;
                r.rdata = bus.pwrite ? 32'd0 : mem[bus.paddr[9:2]];
                bus.prdata = r.rdata;
                bus.pslverr = r.slverr;
                if (bus.pwrite) mem[bus.paddr[9:2]] = bus.pwdata;
                got.push_back(r);
            end
        end
        p_stall = !rst && bus.psel && bus.penable && !bus.pready;
        p_adr = bus.paddr;
        p_wr = bus.pwrite;
        p_wd = bus.pwdata;
    end

    // One run: build the expected word list, drive start, wait for done, compare everything
    task automatic run(input string tag, input logic [1:0] m, input logic [1:0] p, input logic [9:0] b,
                       input int n, input logic [31:0] s, input int st, input int ab, input int se);
        int cyc, lim, ne, ecnt;
        bit ab_hit, first_seen, timed, wr;
        logic [9:0] efirst;
        rec_t e;
        exp_q.delete();
        got.delete();
        stall_max = st;
        abort_at = ab;
        slverr_at = se;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1 && m != 2'd2) continue;
            wr = ph == 0 ? (m == 2'd0 || m == 2'd2) : 1'b0;
            for (int i = 0; i < n; i++) begin
                e.adr = 32'(10'((int'(b) & 'h3FC) + 4 * i));
                e.wr = wr;
                e.data = pat(p, s, i, e.adr[9:0]);
                e.rdata = '0;
                e.slverr = 1'b0;
                exp_q.push_back(e);
            end
        end
        ab_hit = ab >= 0 && ab < exp_q.size();
        if (ab_hit) while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
        timed = st == 0 && !ab_hit;
        @(negedge clk);
        mode = m; pattern = p; base = b; num = 16'(n); seed = s; start = 1'b1;
        cyc = 0;
        lim = 20 * n + 20;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                chk({tag, "_psel_after_start"}, bus.psel, n != 0);
                chk({tag, "_busy_after_start"}, busy, n != 0);
            end
            if (cyc == 2) begin
                start = 1'b1; num = ~num; mode = ~mode; seed = ~seed; base = ~base;
            end
            if (cyc == 3) start = 1'b0;
        end while (!done && cyc < lim);
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        if (timed) chk({tag, "_done_latency"}, cyc, n == 0 ? 1 : (m == 2'd2 ? 4 : 2) * n + 1);
        chk({tag, "_xfer_count"}, got.size(), exp_q.size());
        ne = got.size() < exp_q.size() ? got.size() : exp_q.size();
        ecnt = 0;
        first_seen = 1'b0;
        efirst = '0;
        for (int j = 0; j < ne; j++) begin
            chk({tag, "_addr"}, got[j].adr, exp_q[j].adr);
            chk({tag, "_pwrite"}, got[j].wr, exp_q[j].wr);
            chk({tag, "_pwdata"}, got[j].data, exp_q[j].wr ? exp_q[j].data : 32'd0);
            if (j == se || (!exp_q[j].wr && got[j].rdata != exp_q[j].data)) begin
                if (!first_seen) efirst = exp_q[j].adr[9:0];
                first_seen = 1'b1;
                ecnt++;
            end
        end
        chk({tag, "_err_cnt"}, err_cnt, ecnt);
        chk({tag, "_first_err"}, first_err, efirst);
        chk({tag, "_aborted"}, aborted, ab_hit);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_psel_end"}, bus.psel, 0);
        chk({tag, "_err_hold"}, err_cnt, ecnt);
        abort_at = -1;
        slverr_at = -1;
        stall_max = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (2) @(negedge clk);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err", first_err, 0);
        rst = 1'b0;

        run("t1", 2'd0, 2'd1, 10'h010, 4, 32'h100, 0, -1, -1);
        for (int i = 0; i < 4; i++) chk("t1_mem", mem[4 + i], 32'h100 + 32'(i));

        run("t2", 2'd2, 2'd3, 10'h3F8, 4, 32'h0, 0, -1, -1);
        chk("t2_addr0", got[0].adr, 32'h3F8);
        chk("t2_addr2", got[2].adr, 32'h000);
        chk("t2_addr7", got[7].adr, 32'h004);
        chk("t2_err", err_cnt, 0);

        run("t1b", 2'd0, 2'd1, 10'h010, 4, 32'h100, 0, -1, -1);
        mem[6] = mem[6] ^ 32'h0000_0400;
        run("t3", 2'd1, 2'd1, 10'h010, 4, 32'h100, 0, -1, -1);
        chk("t3_err", err_cnt, 1);
        chk("t3_first", first_err, 10'h018);

        run("t4", 2'd0, 2'd1, 10'h010, 4, 32'h100, 5, -1, -1);
        for (int i = 0; i < 4; i++) chk("t4_mem", mem[4 + i], 32'h100 + 32'(i));
        chk("t4_err", err_cnt, 0);

        run("t5", 2'd0, 2'd0, 10'h100, 8, 32'hA5A5_0000, 0, 2, -1);
        chk("t5_words", got.size(), 3);
        chk("t5_aborted", aborted, 1);
        run("t5z", 2'd0, 2'd0, 10'h100, 0, 32'h1, 0, -1, -1);
        chk("t5z_noxfer", got.size(), 0);

        run("t6", 2'd0, 2'd2, 10'h200, 4, 32'h0, 0, -1, 1);
        chk("t6_err", err_cnt, 1);
        chk("t6_first", first_err, 10'h204);

        @(negedge clk);
        mode = 2'd0; pattern = 2'd0; base = 10'h040; num = 16'd8; seed = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6r_psel", bus.psel, 0);
        chk("t6r_penable", bus.penable, 0);
        chk("t6r_paddr", bus.paddr, 0);
        chk("t6r_pwdata", bus.pwdata, 0);
        chk("t6r_busy", busy, 0);
        chk("t6r_err", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        repeat (6) @(negedge clk);
        chk("t6r_no_resume", got.size(), 0);
        chk("t6r_idle_psel", bus.psel, 0);

        for (int k = 0; k < 24; k++) begin
            int n, ab, se;
            n = int'($urandom_range(10, 0));
            ab = $urandom_range(3, 0) == 0 ? int'($urandom_range(2 * n + 1, 0)) : -1;
            se = $urandom_range(2, 0) == 0 ? int'($urandom_range(2 * n + 1, 0)) : -1;
            run("rnd", 2'($urandom), 2'($urandom), 10'($urandom), n, $urandom,
                int'($urandom_range(3, 0)), ab, se);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
